id_issue_stage: RTL and testbench

//  Parametrised decode-to-issue stage: registered ID/EX boundary behind the combinational decoder.

---
 rtl/id_issue_stage_pkg.sv | 12 +
 rtl/id_load_scoreboard.sv | 39 +++
 rtl/id_issue_stage.sv | 104 ++++++++++
 tb/tb_id_issue_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_issue_stage_pkg.sv
// Shared constants and helpers for the decode-to-issue stage.
package id_issue_stage_pkg;
  localparam logic ENABLE    = 1'b1;
  localparam logic DISABLE   = 1'b0;
  localparam logic DISABLE_N = 1'b1;
  localparam int   HAZ_CNT_W = 16;

  // Width of a load countdown entry able to hold LD_LAT.
  function automatic int sb_cnt_w(input int ld_lat);
    return $clog2(ld_lat + 1);
  endfunction
endpackage

// File: rtl/id_load_scoreboard.sv
// Per-register load countdown: a load arms its destination, the count drains as the pipe advances.
module id_load_scoreboard
  import id_issue_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  dec_en,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic                  busy_a,
  output logic                  busy_b
);
  localparam int NREG = 2**REG_ADDR_W;
  localparam int SB_W = sb_cnt_w(LD_LAT);
  localparam logic [SB_W-1:0] LAT = SB_W'(LD_LAT);

  logic [SB_W-1:0] sb [NREG];
  logic [NREG-1:0] busy;

  for (genvar r = 0; r < NREG; r++) begin : g_sb
    // A fresh load wins over the decrement of the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                       sb[r] <= '0;
      else if (flush)                                   sb[r] <= '0;
      else if (set_en && set_addr == REG_ADDR_W'(r))    sb[r] <= LAT;
      else if (dec_en && busy[r])                       sb[r] <= sb[r] - SB_W'(1);
    end
    assign busy[r] = |sb[r];
  end

  assign busy_a = busy[rd_addr_a];
  assign busy_b = busy[rd_addr_b];
endmodule

// File: rtl/id_issue_stage.sv
// ID/EX boundary: operand forwarding, load-use interlock and a valid/ready output register.
module id_issue_stage
  import id_issue_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 30,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_FWD    = 2,
  parameter int LD_LAT     = 2,
  parameter int PAYLOAD_W  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [REG_ADDR_W-1:0]                in_ra_addr,
  input  logic [REG_ADDR_W-1:0]                in_rb_addr,
  input  logic                                 in_ra_use,
  input  logic                                 in_rb_use,
  input  logic [REG_ADDR_W-1:0]                in_dst_addr,
  input  logic                                 in_gpr_we_n,
  input  logic                                 in_is_load,
  input  logic [ADDR_W-1:0]                    in_pc,
  input  logic [PAYLOAD_W-1:0]                 in_payload,
  input  logic [DATA_W-1:0]                    gpr_rd_data0,
  input  logic [DATA_W-1:0]                    gpr_rd_data1,
  input  logic [NUM_FWD-1:0]                   fwd_en,
  input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0]   fwd_addr,
  input  logic [NUM_FWD-1:0][DATA_W-1:0]       fwd_data,
  input  logic                                 flush,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_W-1:0]                    out_ra_data,
  output logic [DATA_W-1:0]                    out_rb_data,
  output logic [REG_ADDR_W-1:0]                out_dst_addr,
  output logic                                 out_gpr_we_n,
  output logic                                 out_is_load,
  output logic [ADDR_W-1:0]                    out_pc,
  output logic [PAYLOAD_W-1:0]                 out_payload,
  output logic                                 ld_hazard,
  output logic [HAZ_CNT_W-1:0]                 haz_cnt
);
  logic              busy_a, busy_b, fire;
  logic [DATA_W-1:0] ra_data, rb_data;

  // Scan oldest to youngest so the lowest matching index ends up selected.
  function automatic logic [DATA_W-1:0] fwd_mux(input logic [REG_ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0]     rf_data);
    fwd_mux = rf_data;
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (fwd_en[i] && fwd_addr[i] == addr) fwd_mux = fwd_data[i];
  endfunction

  assign ra_data   = fwd_mux(in_ra_addr, gpr_rd_data0);
  assign rb_data   = fwd_mux(in_rb_addr, gpr_rd_data1);
  assign ld_hazard = in_valid & ((in_ra_use & busy_a) | (in_rb_use & busy_b));
  assign in_ready  = ~flush & ~ld_hazard & (~out_valid | out_ready);
  assign fire      = in_valid & in_ready;

  id_load_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .LD_LAT(LD_LAT)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .set_en    (fire & in_is_load & ~in_gpr_we_n),
    .set_addr  (in_dst_addr),
    .dec_en    (out_ready),
    .rd_addr_a (in_ra_addr),
    .rd_addr_b (in_rb_addr),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= DISABLE;
      out_ra_data  <= '0;
      out_rb_data  <= '0;
      out_dst_addr <= '0;
      out_gpr_we_n <= DISABLE_N;
      out_is_load  <= DISABLE;
      out_pc       <= '0;
      out_payload  <= '0;
    end else if (flush) begin
      out_valid    <= DISABLE;
    end else if (fire) begin
      out_valid    <= ENABLE;
      out_ra_data  <= ra_data;
      out_rb_data  <= rb_data;
      out_dst_addr <= in_dst_addr;
      out_gpr_we_n <= in_gpr_we_n;
      out_is_load  <= in_is_load;
      out_pc       <= in_pc;
      out_payload  <= in_payload;
    end else if (out_ready) begin
      out_valid    <= DISABLE;
    end
  end

  // Stall statistics survive flushes; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        haz_cnt <= '0;
    else if (ld_hazard && ~&haz_cnt)   haz_cnt <= haz_cnt + HAZ_CNT_W'(1);
  end
endmodule

// File: tb/tb_id_issue_stage.sv
// Randomized + directed bench; reference model tracks per-register load countdowns as plain ints.
module tb_id_issue_stage;
  localparam int DATA_W = 32, ADDR_W = 30, RAW = 5, NUM_FWD = 2, LD_LAT = 2, PAYLOAD_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0]    ra;
    logic [DATA_W-1:0]    rb;
    logic [RAW-1:0]       dst;
    logic                 we_n;
    logic                 is_load;
    logic [ADDR_W-1:0]    pc;
    logic [PAYLOAD_W-1:0] payload;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid, in_ready, in_ra_use, in_rb_use, in_gpr_we_n, in_is_load, flush, out_ready;
  logic [RAW-1:0] in_ra_addr, in_rb_addr, in_dst_addr, out_dst_addr;
  logic [ADDR_W-1:0] in_pc, out_pc;
  logic [PAYLOAD_W-1:0] in_payload, out_payload;
  logic [DATA_W-1:0] gpr_rd_data0, gpr_rd_data1, out_ra_data, out_rb_data;
  logic [NUM_FWD-1:0] fwd_en;
  logic [NUM_FWD-1:0][RAW-1:0] fwd_addr;
  logic [NUM_FWD-1:0][DATA_W-1:0] fwd_data;
  logic out_valid, out_gpr_we_n, out_is_load, ld_hazard;
  logic [15:0] haz_cnt;

  int total = 0, bad = 0;
  exp_t exp_q[$];
  int sb_m[32];
  bit m_valid = 0;
  int m_cnt = 0;
  bit s_haz, s_fire, s_rdy;

  always #5 clk = ~clk;

  id_issue_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_ADDR_W(RAW), .NUM_FWD(NUM_FWD),
                   .LD_LAT(LD_LAT), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_ra_use(in_ra_use), .in_rb_use(in_rb_use),
    .in_dst_addr(in_dst_addr), .in_gpr_we_n(in_gpr_we_n), .in_is_load(in_is_load), .in_pc(in_pc),
    .in_payload(in_payload), .gpr_rd_data0(gpr_rd_data0), .gpr_rd_data1(gpr_rd_data1),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ra_data(out_ra_data), .out_rb_data(out_rb_data),
    .out_dst_addr(out_dst_addr), .out_gpr_we_n(out_gpr_we_n), .out_is_load(out_is_load),
    .out_pc(out_pc), .out_payload(out_payload), .ld_hazard(ld_hazard), .haz_cnt(haz_cnt)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] fwd_model(logic [RAW-1:0] a, logic [DATA_W-1:0] rf);
    for (int i = 0; i < NUM_FWD; i++)
      if (fwd_en[i] && fwd_addr[i] == a) return fwd_data[i];
    return rf;
  endfunction

  // One clock of stimulus: inputs already applied at posedge+1; returns at next posedge+1.
  task automatic cycle();
    bit haz, rdy, fire;
    exp_t e;
    haz  = in_valid && ((in_ra_use && sb_m[in_ra_addr] > 0) || (in_rb_use && sb_m[in_rb_addr] > 0));
    rdy  = !flush && !haz && (!m_valid || out_ready);
    fire = in_valid && rdy;
    @(negedge clk);
    chk("in_ready", in_ready, rdy);
    chk("ld_hazard", ld_hazard, haz);
    chk("out_valid", out_valid, m_valid);
    chk("haz_cnt", haz_cnt, m_cnt);
    s_haz = ld_hazard; s_rdy = in_ready; s_fire = in_valid & in_ready;
    if (fire) begin
      e.ra = fwd_model(in_ra_addr, gpr_rd_data0);
      e.rb = fwd_model(in_rb_addr, gpr_rd_data1);
      e.dst = in_dst_addr; e.we_n = in_gpr_we_n; e.is_load = in_is_load;
      e.pc = in_pc; e.payload = in_payload;
      exp_q.push_back(e);
    end
    if (haz && m_cnt != 16'hFFFF) m_cnt++;
    if (flush) begin
      foreach (sb_m[r]) sb_m[r] = 0;
      m_valid = 0;
    end else begin
      if (out_ready) foreach (sb_m[r]) if (sb_m[r] > 0) sb_m[r]--;
      if (fire && in_is_load && !in_gpr_we_n) sb_m[in_dst_addr] = LD_LAT;
      if (fire) m_valid = 1; else if (out_ready) m_valid = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic set_insn(int ra, int rb, bit ra_use, bit rb_use, int dst, bit we_n, bit is_load);
    in_valid = 1; in_ra_addr = RAW'(ra); in_rb_addr = RAW'(rb);
    in_ra_use = ra_use; in_rb_use = rb_use; in_dst_addr = RAW'(dst);
    in_gpr_we_n = we_n; in_is_load = is_load;
    in_pc = ADDR_W'($urandom); in_payload = PAYLOAD_W'($urandom);
    gpr_rd_data0 = $urandom; gpr_rd_data1 = $urandom;
  endtask

  task automatic idle(int n);
    in_valid = 0; flush = 0; out_ready = 1; fwd_en = '0;
    repeat (n) cycle();
  endtask

  // Load r5 then a reader of r5; out_ready low for the first hold_cycles of the stall.
  task automatic load_use(int hold_cycles, int exp_stalls);
    int stalls = 0, n = 0, c0;
    idle(4);
    c0 = m_cnt;
    set_insn(0, 0, 0, 0, 5, 0, 1);
    cycle();
    set_insn(5, 1, 1, 0, 2, 1, 0);
    do begin
      out_ready = (n < hold_cycles) ? 1'b0 : 1'b1;
      cycle();
      if (s_haz) stalls++;
      n++;
    end while (!s_fire && n < 12);
    chk("lu_fired", s_fire, 1);
    chk("lu_stalls", stalls, exp_stalls);
    chk("lu_haz_cnt", haz_cnt - 16'(c0), exp_stalls);
  endtask

  // Scoreboard side: compare whenever EX takes an instruction; a flushed one is dropped.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (flush) begin
          if (exp_q.size() > 0) e = exp_q.pop_front();
        end else if (out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("out_ra_data", out_ra_data, e.ra);
            chk("out_rb_data", out_rb_data, e.rb);
            chk("out_ctl", {out_dst_addr, out_gpr_we_n, out_is_load, out_pc, out_payload},
                {e.dst, e.we_n, e.is_load, e.pc, e.payload});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] pc_a;
    in_valid = 0; in_ra_addr = 0; in_rb_addr = 0; in_ra_use = 0; in_rb_use = 0; in_dst_addr = 0;
    in_gpr_we_n = 1; in_is_load = 0; in_pc = 0; in_payload = 0; gpr_rd_data0 = 0; gpr_rd_data1 = 0;
    fwd_en = 0; fwd_addr = 0; fwd_data = 0; flush = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_gpr_we_n", out_gpr_we_n, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_haz_cnt", haz_cnt, 0);
    chk("rst_data", {out_ra_data, out_pc}, 0);
    @(posedge clk); #1;

    // Both forward sources hit r3: index 0 must win.
    set_insn(3, 4, 1, 1, 9, 0, 0);
    fwd_en = 2'b11; fwd_addr[0] = 5'd3; fwd_addr[1] = 5'd3;
    fwd_data[0] = 32'hAAAA; fwd_data[1] = 32'h5555;
    cycle();
    chk("fwd_priority", out_ra_data, 32'hAAAA);
    fwd_en = 0;

    load_use(0, LD_LAT);
    load_use(3, LD_LAT + 3);

    // Back-pressure holds the output and blocks intake.
    idle(3);
    out_ready = 0;
    set_insn(1, 2, 0, 0, 3, 1, 0);
    pc_a = in_pc;
    cycle();
    set_insn(1, 2, 0, 0, 4, 1, 0);
    cycle();
    chk("bp_stall_ready", s_rdy, 0);
    chk("bp_hold_pc", out_pc, pc_a);
    out_ready = 1;
    cycle();
    chk("bp_new_pc", out_pc, in_pc);
    chk("bp_new_valid", out_valid, 1);

    // Flush kills the output and the pending r7 countdown.
    idle(3);
    set_insn(0, 0, 0, 0, 7, 0, 1);
    cycle();
    set_insn(7, 7, 1, 1, 8, 1, 0);
    flush = 1;
    cycle();
    chk("flush_no_fire", s_fire, 0);
    chk("flush_out_valid", out_valid, 0);
    flush = 0;
    cycle();
    chk("post_flush_haz", s_haz, 0);
    chk("post_flush_fire", s_fire, 1);

    // Random traffic over a small register window to provoke hazards and forwarding.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) < 8)
        set_insn($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 7), 1'($urandom), 1'($urandom));
      else in_valid = 0;
      for (int i = 0; i < NUM_FWD; i++) begin
        fwd_en[i] = 1'($urandom);
        fwd_addr[i] = RAW'($urandom_range(0, 7));
        fwd_data[i] = $urandom;
      end
      flush = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    idle(6);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
